sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
//  Shares the single sdram_ctrl internal port (idle/adr/dat/sel/acc/ack/we) among NUM_PORTS requesters
//  (e.g. video scan-out, CPU, blitter). Sits between the requesters and sdram_ctrl, in the sdram_clk domain.
//  Round-robin arbitration; a grant is held for the whole access (incl. burst) and released only once
//  the requester drops acc and sdram_ctrl reports idle again.
// PARAMETERS
//  NUM_PORTS   2   requester count, 2..4
//  ADR_WIDTH   32  address width, matches sdram_ctrl adr_i/adr_o
//  DAT_WIDTH   16  data width, matches sdram_ctrl dat_i/dat_o; sel width = DAT_WIDTH/8
// PORTS
//  sdram_clk    in   1                    single clock; all logic posedge
//  sdram_rst    in   1                    reset, synchronous, active-high
//  port_acc_i   in   NUM_PORTS            per-port access request (level, held until last ack)
//  port_we_i    in   NUM_PORTS            per-port write enable
//  port_adr_i   in   NUM_PORTS*ADR_WIDTH  per-port address, port k at [k*ADR_WIDTH +: ADR_WIDTH]
//  port_dat_i   in   NUM_PORTS*DAT_WIDTH  per-port write data, same packing
//  port_sel_i   in   NUM_PORTS*DAT_WIDTH/8 per-port byte select, same packing
//  port_ack_o   out  NUM_PORTS            per-port ack; only the granted bit can be 1
//  port_dat_o   out  DAT_WIDTH            read data, broadcast (valid with that port's ack)
//  port_adr_o   out  ADR_WIDTH            address of returned word, broadcast
//  sc_idle_i    in   1                    sdram_ctrl idle_o
//  sc_acc_o, sc_we_o  out 1               to sdram_ctrl acc_i / we_i
//  sc_adr_o     out  ADR_WIDTH            to sdram_ctrl adr_i
//  sc_dat_o     out  DAT_WIDTH            to sdram_ctrl dat_i
//  sc_sel_o     out  DAT_WIDTH/8          to sdram_ctrl sel_i
//  sc_ack_i     in   1                    sdram_ctrl ack_o
//  sc_dat_i, sc_adr_i in DAT/ADR_WIDTH    sdram_ctrl dat_o / adr_o
//  grant_o      out  $clog2(NUM_PORTS)    current/last granted port (status)
//  busy_o       out  1                    1 in ARB_BUSY or ARB_DRAIN
// BEHAVIOUR
//  States: ARB_IDLE, ARB_BUSY, ARB_DRAIN (registered). Reset: state=ARB_IDLE, grant=0,
//   last=NUM_PORTS-1 (port 0 wins first); sc_acc_o=0, port_ack_o=0, busy_o=0 in the cycle after reset.
//  ARB_IDLE: sc_acc_o=0, port_ack_o=0. If sc_idle_i=1 and any port_acc_i=1: grant <= first requesting
//   port searching last+1, last+2, ... (mod NUM_PORTS); state <= ARB_BUSY. Else stay.
//   Latency: request sampled at edge n -> sc_acc_o high from cycle n+1 (one cycle).
//  ARB_BUSY: combinational pass-through from granted port: sc_acc_o=port_acc_i[grant], sc_we/adr/dat/sel
//   from port grant; port_ack_o[grant]=sc_ack_i, all other acks 0. If port_acc_i[grant]=0 at an edge:
//   last <= grant, state <= ARB_DRAIN (sc_acc_o already 0 in that cycle).
//  ARB_DRAIN: sc_acc_o=0, acks 0; state <= ARB_IDLE when sc_idle_i=1. No new grant decided in DRAIN.
//  sc_adr/dat/sel/we outside ARB_BUSY: driven from port grant (don't-care for sdram_ctrl, kept stable).
//  port_dat_o=sc_dat_i, port_adr_o=sc_adr_i always (no registering; no added read latency).
//  Boundaries:
//   - simultaneous requests: strict round-robin; a lone requester may be re-granted after DRAIN->IDLE.
//   - requester drops acc before grant edge: not granted. Drops on first BUSY cycle: no access issued,
//     straight to DRAIN, last updated (counts as its turn).
//   - sc_idle_i low in IDLE (refresh/init): requests wait, no grant.
//   - sc_ack_i while sc_acc_o=0 (late burst beats): forwarded to granted port only in BUSY; dropped in DRAIN.
//   - sdram_rst mid-access: next cycle ARB_IDLE, sc_acc_o=0; sdram_ctrl is reset by the same signal.
//   - NUM_PORTS outside 2..4: elaboration error ($error in generate).
// STRUCTURE
//  sdram_arb_pkg: arb_state_t enum {ARB_IDLE, ARB_BUSY, ARB_DRAIN}; MAX_PORTS=4 constant.
//  Sub-module rr_pick (combinational): req[N], last -> found, idx. Rest (FSM, muxes) in this module.
// TESTING (bench with sdram_ctrl + sdram sim model, BURST_LENGTH=8, POWERUP_DELAY=0)
//  1 Reset then port0 writes 16'h1000 @32'h1000: sc_acc_o high 1 cycle after acc; port_ack_o=01; port1 ack 0.
//  2 Both ports acc same cycle after reset: port0 granted first, port1 granted after port0 drops acc and
//    sc_idle_i=1; grant_o 0 then 1; no overlap of sc_acc_o between grants.
//  3 Port1 writes 16'h2000 @32'h2000, port0 reads 8-beat burst @32'h2000: first ack'd word 16'h2000,
//    8 acks all on port_ack_o[0], port_adr_o advances with sc_adr_i.
//  4 Port0 requests continuously, port1 requests once: port1 granted on the next arbitration (no starvation).
//  5 Port raises acc then drops it on first BUSY cycle: sc_acc_o never 1, FSM IDLE->BUSY->DRAIN->IDLE.
//  6 sdram_rst asserted mid-burst: next cycle busy_o=0, sc_acc_o=0, port_ack_o=0; fresh request served
//    after sdram_ctrl idle; NUM_PORTS=3 variant repeats 2 with three-way rotation 0,1,2.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter.
//   arb_state_t : arbiter FSM encoding
//   MAX_PORTS   : largest supported requester count
package sdram_arb_pkg;

    localparam int MAX_PORTS = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BUSY  = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sdram_port_arbiter_rr_pick.sv
// Round-robin picker (purely combinational).
//   req   : per-port request bits
//   last  : port that had the most recent turn
//   found : at least one request present
//   idx   : first requesting port searching last+1, last+2, ... (mod N)
module rr_pick
    import sdram_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Walk the ring from farthest to nearest so the nearest hit wins.
    always_comb begin
        logic [IW-1:0] k;
        found = 1'b0;
        idx   = '0;
        k     = '0;
        for (int i = N; i >= 1; i--) begin
            k = IW'((int'(last) + i) % N);
            if (req[k]) begin
                found = 1'b1;
                idx   = k;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the single sdram_ctrl internal port among NUM_PORTS requesters with
// round-robin arbitration. A grant is held across the whole access (bursts
// included) and released once the requester drops acc and the controller
// reports idle again.
//
// Ports
//   sdram_clk, sdram_rst           : clock, synchronous active-high reset
//   port_acc_i/we_i/adr_i/dat_i/sel_i : packed per-port requests (port k at [k*W +: W])
//   port_ack_o                     : per-port ack, only the granted bit can be set
//   port_dat_o/adr_o               : read data / address, broadcast from sdram_ctrl
//   sc_*                           : sdram_ctrl internal port
//   grant_o, busy_o                : status
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ARB_IDLE  | no grant active; pick next requester when controller idle
// ARB_BUSY  | granted port passed straight through to sdram_ctrl
// ARB_DRAIN | requester released; wait for controller to go idle
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter  int NUM_PORTS = 2,
    parameter  int ADR_WIDTH = 32,
    parameter  int DAT_WIDTH = 16,
    localparam int SEL_WIDTH = DAT_WIDTH / 8,
    localparam int GW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                           sdram_clk,
    input  logic                           sdram_rst,
    input  logic [NUM_PORTS-1:0]           port_acc_i,
    input  logic [NUM_PORTS-1:0]           port_we_i,
    input  logic [NUM_PORTS*ADR_WIDTH-1:0] port_adr_i,
    input  logic [NUM_PORTS*DAT_WIDTH-1:0] port_dat_i,
    input  logic [NUM_PORTS*SEL_WIDTH-1:0] port_sel_i,
    output logic [NUM_PORTS-1:0]           port_ack_o,
    output logic [DAT_WIDTH-1:0]           port_dat_o,
    output logic [ADR_WIDTH-1:0]           port_adr_o,
    input  logic                           sc_idle_i,
    output logic                           sc_acc_o,
    output logic                           sc_we_o,
    output logic [ADR_WIDTH-1:0]           sc_adr_o,
    output logic [DAT_WIDTH-1:0]           sc_dat_o,
    output logic [SEL_WIDTH-1:0]           sc_sel_o,
    input  logic                           sc_ack_i,
    input  logic [DAT_WIDTH-1:0]           sc_dat_i,
    input  logic [ADR_WIDTH-1:0]           sc_adr_i,
    output logic [GW-1:0]                  grant_o,
    output logic                           busy_o
);

    if (NUM_PORTS < 2 || NUM_PORTS > MAX_PORTS) begin : g_bad_num_ports
        $error("sdram_port_arbiter: NUM_PORTS must be 2..%0d", MAX_PORTS);
    end

    arb_state_t    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_q,  last_d;
    logic          pick_found;
    logic [GW-1:0] pick_idx;

    rr_pick #(.N(NUM_PORTS), .IW(GW)) u_rr_pick (
        .req   (port_acc_i),
        .last  (last_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (sc_idle_i && pick_found) begin
                    grant_d = pick_idx;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                // Dropping acc ends the turn even if no access was issued.
                if (!port_acc_i[grant_q]) begin
                    last_d  = grant_q;
                    state_d = ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                if (sc_idle_i) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_PORTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Request fields always follow the granted port so they stay stable
    // outside BUSY; only acc and ack are gated by the state.
    always_comb begin
        port_ack_o = '0;
        sc_acc_o   = (state_q == ARB_BUSY) && port_acc_i[grant_q];
        if (state_q == ARB_BUSY) port_ack_o[grant_q] = sc_ack_i;
        sc_we_o  = port_we_i[grant_q];
        sc_adr_o = port_adr_i[int'(grant_q) * ADR_WIDTH +: ADR_WIDTH];
        sc_dat_o = port_dat_i[int'(grant_q) * DAT_WIDTH +: DAT_WIDTH];
        sc_sel_o = port_sel_i[int'(grant_q) * SEL_WIDTH +: SEL_WIDTH];
    end

    assign port_dat_o = sc_dat_i;
    assign port_adr_o = sc_adr_i;
    assign grant_o    = grant_q;
    assign busy_o     = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;

    localparam int NP = 2;
    localparam int AW = 32;
    localparam int DW = 16;
    localparam int SW = DW / 8;

    logic sdram_clk = 1'b0;
    logic sdram_rst;
    always #5 sdram_clk = ~sdram_clk;

    logic [NP-1:0]    port_acc_i, port_we_i, port_ack_o;
    logic [NP*AW-1:0] port_adr_i;
    logic [NP*DW-1:0] port_dat_i;
    logic [NP*SW-1:0] port_sel_i;
    logic [DW-1:0]    port_dat_o, sc_dat_o, sc_dat_i;
    logic [AW-1:0]    port_adr_o, sc_adr_o, sc_adr_i;
    logic [SW-1:0]    sc_sel_o;
    logic             sc_idle_i, sc_acc_o, sc_we_o, sc_ack_i, busy_o;
    logic [0:0]       grant_o;

    logic          req_acc [NP];
    logic          req_we  [NP];
    logic [AW-1:0] req_adr [NP];
    logic [DW-1:0] req_dat [NP];
    logic [SW-1:0] req_sel [NP];

    always_comb begin
        port_acc_i = '0; port_we_i = '0; port_adr_i = '0; port_dat_i = '0; port_sel_i = '0;
        for (int k = 0; k < NP; k++) begin
            port_acc_i[k]           = req_acc[k];
            port_we_i[k]            = req_we[k];
            port_adr_i[k*AW +: AW]  = req_adr[k];
            port_dat_i[k*DW +: DW]  = req_dat[k];
            port_sel_i[k*SW +: SW]  = req_sel[k];
        end
    end

    logic model_busy, refresh, model_abort, req_abort;
    assign sc_idle_i = !model_busy && !refresh;

    sdram_port_arbiter #(.NUM_PORTS(NP), .ADR_WIDTH(AW), .DAT_WIDTH(DW)) dut (
        .sdram_clk(sdram_clk), .sdram_rst(sdram_rst),
        .port_acc_i(port_acc_i), .port_we_i(port_we_i), .port_adr_i(port_adr_i),
        .port_dat_i(port_dat_i), .port_sel_i(port_sel_i), .port_ack_o(port_ack_o),
        .port_dat_o(port_dat_o), .port_adr_o(port_adr_o), .sc_idle_i(sc_idle_i),
        .sc_acc_o(sc_acc_o), .sc_we_o(sc_we_o), .sc_adr_o(sc_adr_o), .sc_dat_o(sc_dat_o),
        .sc_sel_o(sc_sel_o), .sc_ack_i(sc_ack_i), .sc_dat_i(sc_dat_i), .sc_adr_i(sc_adr_i),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    // Three-port instance: idle controller, no acks, rotation only.
    logic [2:0]    acc3, we3, ack3;
    logic [3*AW-1:0] adr3;
    logic [3*DW-1:0] dat3;
    logic [3*SW-1:0] sel3;
    logic [DW-1:0] pdat3, scdat3;
    logic [AW-1:0] padr3, scadr3;
    logic [SW-1:0] scsel3;
    logic          scacc3, scwe3, busy3, idle3, scack3;
    logic [1:0]    grant3;

    sdram_port_arbiter #(.NUM_PORTS(3), .ADR_WIDTH(AW), .DAT_WIDTH(DW)) dut3 (
        .sdram_clk(sdram_clk), .sdram_rst(sdram_rst),
        .port_acc_i(acc3), .port_we_i(we3), .port_adr_i(adr3), .port_dat_i(dat3),
        .port_sel_i(sel3), .port_ack_o(ack3), .port_dat_o(pdat3), .port_adr_o(padr3),
        .sc_idle_i(idle3), .sc_acc_o(scacc3), .sc_we_o(scwe3), .sc_adr_o(scadr3),
        .sc_dat_o(scdat3), .sc_sel_o(scsel3), .sc_ack_i(scack3), .sc_dat_i(16'h0),
        .sc_adr_i(32'h0), .grant_o(grant3), .busy_o(busy3)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct { int port; logic [AW-1:0] adr; logic [DW-1:0] dat; bit chk_dat; } ack_t;
    typedef struct { int port; logic [AW-1:0] adr; logic [DW-1:0] dat; logic [SW-1:0] sel; bit we; } gnt_t;
    ack_t ack_q[$];
    gnt_t gnt_q[$];
    int   ack_cnt [NP];

    task automatic push_gnt(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s, input bit we);
        gnt_t g;
        g.port = p; g.adr = a; g.dat = d; g.sel = s; g.we = we;
        gnt_q.push_back(g);
    endtask

    task automatic push_ack(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit cd);
        ack_t e;
        e.port = p; e.adr = a; e.dat = d; e.chk_dat = cd;
        ack_q.push_back(e);
    endtask

    // Monitor: compares every presented ack and every new sc_acc_o grant.
    initial begin
        logic    prev_acc;
        ack_t    e;
        gnt_t    g;
        logic [NP-1:0] m;
        prev_acc = 1'b0;
        forever begin
            @(negedge sdram_clk);
            if (!sdram_rst) begin
                if (port_ack_o != '0) begin
                    for (int k = 0; k < NP; k++) if (port_ack_o[k]) ack_cnt[k]++;
                    if (ack_q.size() == 0) begin
                        chk("unexpected_ack", 64'(port_ack_o), 64'(0));
                    end else begin
                        e = ack_q.pop_front();
                        m = '0; m[e.port] = 1'b1;
                        chk("ack_port", 64'(port_ack_o), 64'(m));
                        chk("ack_adr", 64'(port_adr_o), 64'(e.adr));
                        if (e.chk_dat) chk("ack_dat", 64'(port_dat_o), 64'(e.dat));
                    end
                end
                if (sc_acc_o && !prev_acc) begin
                    if (gnt_q.size() == 0) begin
                        chk("unexpected_sc_acc", 64'(sc_acc_o), 64'(0));
                    end else begin
                        g = gnt_q.pop_front();
                        chk("gnt_port", 64'(grant_o), 64'(g.port));
                        chk("gnt_adr", 64'(sc_adr_o), 64'(g.adr));
                        chk("gnt_we", 64'(sc_we_o), 64'(g.we));
                        chk("gnt_sel", 64'(sc_sel_o), 64'(g.sel));
                        if (g.we) chk("gnt_dat", 64'(sc_dat_o), 64'(g.dat));
                    end
                end
            end
            prev_acc = sc_acc_o;
        end
    end

    // Behavioural sdram_ctrl: 1-beat writes, 8-beat linear read bursts.
    logic [DW-1:0] mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return a[DW-1:0] ^ 16'h5A5A;
    endfunction

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          w;
        int            n;
        model_busy = 1'b0; sc_ack_i = 1'b0; sc_dat_i = '0; sc_adr_i = '0;
        forever begin
            @(negedge sdram_clk);
            if (sc_acc_o && sc_idle_i && !sdram_rst) begin
                a = sc_adr_o; w = sc_we_o; d = sc_dat_o; n = w ? 1 : 8;
                @(posedge sdram_clk); #1 model_busy = 1'b1;
                @(posedge sdram_clk); #1;
                if (w) mem[a] = d;
                for (int i = 0; i < n && !model_abort; i++) begin
                    sc_ack_i = 1'b1;
                    sc_adr_i = a + 32'(i);
                    sc_dat_i = w ? 16'h0 : rd(a + 32'(i));
                    @(posedge sdram_clk); #1;
                end
                sc_ack_i = 1'b0;
                if (model_abort) repeat (3) @(posedge sdram_clk);
                @(posedge sdram_clk); #1 model_busy = 1'b0;
            end
        end
    end

    // Requester: raise acc, hold until the last ack, then drop.
    task automatic access(input int p, input bit we, input logic [AW-1:0] adr,
                          input logic [DW-1:0] dat, input logic [SW-1:0] sel, input int nbeats);
        int seen;
        int budget;
        seen = 0; budget = 0;
        @(posedge sdram_clk); #1;
        req_acc[p] = 1'b1; req_we[p] = we; req_adr[p] = adr; req_dat[p] = dat; req_sel[p] = sel;
        while (seen < nbeats && !req_abort && budget < 400) begin
            @(negedge sdram_clk);
            budget++;
            if (port_ack_o[p]) seen++;
        end
        if (budget >= 400) chk("req_timeout_beats", 64'(seen), 64'(nbeats));
        @(posedge sdram_clk); #1 req_acc[p] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge sdram_clk); #1 sdram_rst = 1'b1;
        @(posedge sdram_clk); #1 sdram_rst = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        while ((busy_o || model_busy) && n < 300) begin
            @(negedge sdram_clk);
            n++;
        end
        if (n >= 300) chk(name, 64'(busy_o), 64'(0));
        chk("sb_ack_empty", 64'(ack_q.size()), 64'(0));
        chk("sb_gnt_empty", 64'(gnt_q.size()), 64'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        sdram_rst = 1'b1; refresh = 1'b0; model_abort = 1'b0; req_abort = 1'b0;
        for (int k = 0; k < NP; k++) begin
            req_acc[k] = 1'b0; req_we[k] = 1'b0; req_adr[k] = '0; req_dat[k] = '0; req_sel[k] = '0;
            ack_cnt[k] = 0;
        end
        acc3 = '0; we3 = '0; adr3 = '0; dat3 = '0; sel3 = '0; idle3 = 1'b1; scack3 = 1'b0;
        repeat (3) @(posedge sdram_clk);
        #1 sdram_rst = 1'b0;

        // 1: reset state, single write, one-cycle grant latency
        @(negedge sdram_clk);
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_sc_acc", 64'(sc_acc_o), 64'(0));
        chk("rst_ack", 64'(port_ack_o), 64'(0));
        chk("rst_grant", 64'(grant_o), 64'(0));
        push_gnt(0, 32'h1000, 16'h1000, 2'b11, 1'b1);
        push_ack(0, 32'h1000, 16'h0, 1'b0);
        fork
            access(0, 1'b1, 32'h1000, 16'h1000, 2'b11, 1);
            begin
                @(posedge sdram_clk);
                @(negedge sdram_clk);
                chk("t1_acc_lat_c0", 64'(sc_acc_o), 64'(0));
                @(negedge sdram_clk);
                chk("t1_acc_lat_c1", 64'(sc_acc_o), 64'(1));
            end
        join
        wait_quiet("t1_quiet");

        // 2: simultaneous requests after reset -> 0 then 1
        do_reset();
        push_gnt(0, 32'h3000, 16'h3000, 2'b11, 1'b1);
        push_gnt(1, 32'h3100, 16'h3100, 2'b01, 1'b1);
        push_ack(0, 32'h3000, 16'h0, 1'b0);
        push_ack(1, 32'h3100, 16'h0, 1'b0);
        fork
            access(0, 1'b1, 32'h3000, 16'h3000, 2'b11, 1);
            access(1, 1'b1, 32'h3100, 16'h3100, 2'b01, 1);
        join
        wait_quiet("t2_quiet");

        // 3: port1 write, port0 8-beat read burst of the same address
        push_gnt(1, 32'h2000, 16'h2000, 2'b10, 1'b1);
        push_ack(1, 32'h2000, 16'h0, 1'b0);
        access(1, 1'b1, 32'h2000, 16'h2000, 2'b10, 1);
        wait_quiet("t3a_quiet");
        push_gnt(0, 32'h2000, 16'h0, 2'b11, 1'b0);
        push_ack(0, 32'h2000, 16'h2000, 1'b1);
        for (int i = 1; i < 8; i++)
            push_ack(0, 32'h2000 + 32'(i), 16'(32'h2000 + i) ^ 16'h5A5A, 1'b1);
        access(0, 1'b0, 32'h2000, 16'h0, 2'b11, 8);
        wait_quiet("t3b_quiet");

        // 4: port0 back-to-back, port1 once -> 0, 1, 0
        push_gnt(0, 32'h4000, 16'h4000, 2'b11, 1'b1);
        push_gnt(1, 32'h4100, 16'h4100, 2'b01, 1'b1);
        push_gnt(0, 32'h4010, 16'h4010, 2'b11, 1'b1);
        push_ack(0, 32'h4000, 16'h0, 1'b0);
        push_ack(1, 32'h4100, 16'h0, 1'b0);
        push_ack(0, 32'h4010, 16'h0, 1'b0);
        fork
            begin
                access(0, 1'b1, 32'h4000, 16'h4000, 2'b11, 1);
                access(0, 1'b1, 32'h4010, 16'h4010, 2'b11, 1);
            end
            begin
                repeat (3) @(posedge sdram_clk);
                access(1, 1'b1, 32'h4100, 16'h4100, 2'b01, 1);
            end
        join
        wait_quiet("t4_quiet");

        // 5: port1 drops acc in its first BUSY cycle; that still counts as its turn
        @(posedge sdram_clk); #1 req_acc[1] = 1'b1; req_adr[1] = 32'h5000; req_we[1] = 1'b0;
        @(posedge sdram_clk); #1 req_acc[1] = 1'b0;
        @(negedge sdram_clk);
        chk("t5_busy_c0", 64'(busy_o), 64'(1));
        chk("t5_grant", 64'(grant_o), 64'(1));
        chk("t5_sc_acc", 64'(sc_acc_o), 64'(0));
        @(negedge sdram_clk);
        chk("t5_drain_busy", 64'(busy_o), 64'(1));
        @(negedge sdram_clk);
        chk("t5_idle_busy", 64'(busy_o), 64'(0));
        push_gnt(0, 32'h5100, 16'h5100, 2'b11, 1'b1);
        push_gnt(1, 32'h5200, 16'h5200, 2'b01, 1'b1);
        push_ack(0, 32'h5100, 16'h0, 1'b0);
        push_ack(1, 32'h5200, 16'h0, 1'b0);
        fork
            access(0, 1'b1, 32'h5100, 16'h5100, 2'b11, 1);
            access(1, 1'b1, 32'h5200, 16'h5200, 2'b01, 1);
        join
        wait_quiet("t5_quiet");

        // controller not idle: request waits, served once idle returns
        refresh = 1'b1;
        push_gnt(1, 32'h5300, 16'h5300, 2'b01, 1'b1);
        push_ack(1, 32'h5300, 16'h0, 1'b0);
        fork
            access(1, 1'b1, 32'h5300, 16'h5300, 2'b01, 1);
            begin
                repeat (5) @(negedge sdram_clk);
                chk("refresh_busy", 64'(busy_o), 64'(0));
                chk("refresh_sc_acc", 64'(sc_acc_o), 64'(0));
                @(posedge sdram_clk); #1 refresh = 1'b0;
            end
        join
        wait_quiet("refresh_quiet");

        // 6: reset mid-burst, then a fresh request
        push_gnt(0, 32'h6000, 16'h0, 2'b11, 1'b0);
        for (int i = 0; i < 8; i++) push_ack(0, 32'h6000 + 32'(i), 16'h0, 1'b0);
        base = ack_cnt[0];
        fork
            access(0, 1'b0, 32'h6000, 16'h0, 2'b11, 8);
            begin
                n = 0;
                while (ack_cnt[0] < base + 3 && n < 100) begin
                    @(negedge sdram_clk);
                    n++;
                end
                chk("t6_beats_before_rst", 64'(ack_cnt[0] >= base + 3), 64'(1));
                @(posedge sdram_clk);
                model_abort = 1'b1; req_abort = 1'b1;
                #1 sdram_rst = 1'b1;
                @(posedge sdram_clk); #1 sdram_rst = 1'b0;
                @(negedge sdram_clk);
                chk("t6_busy", 64'(busy_o), 64'(0));
                chk("t6_sc_acc", 64'(sc_acc_o), 64'(0));
                chk("t6_ack", 64'(port_ack_o), 64'(0));
                chk("t6_grant", 64'(grant_o), 64'(0));
            end
        join
        ack_q.delete();
        req_abort = 1'b0;
        n = 0;
        while (model_busy && n < 100) begin
            @(negedge sdram_clk);
            n++;
        end
        model_abort = 1'b0;
        push_gnt(1, 32'h6100, 16'h6100, 2'b01, 1'b1);
        push_ack(1, 32'h6100, 16'h0, 1'b0);
        access(1, 1'b1, 32'h6100, 16'h6100, 2'b01, 1);
        wait_quiet("t6_quiet");

        // three-port rotation 0, 1, 2
        @(posedge sdram_clk); #1 acc3 = 3'b111;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!scacc3 && n < 20) begin
                @(negedge sdram_clk);
                n++;
            end
            chk("np3_sc_acc", 64'(scacc3), 64'(1));
            chk("np3_grant", 64'(grant3), 64'(k));
            @(posedge sdram_clk); #1 acc3[k] = 1'b0;
            @(negedge sdram_clk);
        end

        repeat (4) @(negedge sdram_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
